// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI receive deserializer.
//   rx_state_e    : frame FSM states (idle between frames, shifting inside a frame)
//   SPI_STD       : one data bit per SCLK rising edge on sdi[0]
//   SPI_QUAD_RX   : four data bits per SCLK rising edge on sdi[3:0]
//   bits_per_edge : number of bits a single SCLK edge contributes in a given mode
package spi_rx_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } rx_state_e;

    localparam logic [1:0] SPI_STD     = 2'b00;
    localparam logic [1:0] SPI_QUAD_RX = 2'b10;

    function automatic int unsigned bits_per_edge(logic [1:0] mode);
        return (mode == SPI_QUAD_RX) ? 32'd4 : 32'd1;
    endfunction

endpackage

// File: rtl/spi_rx_deserializer_if.sv
// Word stream leaving the deserializer (valid/ready handshake).
//   word_data_o  : head-of-buffer word
//   word_valid_o : word_data_o holds a valid word
//   word_ready_i : consumer accepts the word when high together with word_valid_o
// The master modport is the word producer, the slave modport is the consumer.
interface spi_rx_deserializer_if #(
    parameter int unsigned WORD_W = 32
) ();

    logic [WORD_W-1:0] word_data_o;
    logic              word_valid_o;
    logic              word_ready_i;

    modport master (
        output word_data_o,
        output word_valid_o,
        input  word_ready_i
    );

    modport slave (
        input  word_data_o,
        input  word_valid_o,
        output word_ready_i
    );

endinterface

// File: rtl/spi_rx_fifo.sv
// Synchronous FIFO with valid/ready on both sides.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   in_data_i   : write data;   in_valid_i / in_ready_o  : write handshake
//   out_data_o  : head entry;   out_valid_o / out_ready_i: read handshake
//   full_o      : all Depth entries occupied
// When full, a write is still accepted if a read happens in the same cycle.
// Depth must be a power of two (>= 2) so the pointers wrap on their own.
module spi_rx_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             full_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW:0]   count_q;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty       = (count_q == '0);
    assign full_o      = (count_q == (AddrW + 1)'(Depth));
    assign out_valid_o = ~empty;
    assign out_data_o  = mem_q[rd_ptr_q];
    // A pop while full frees the slot the incoming word needs.
    assign in_ready_o  = ~full_o | out_ready_i;
    assign pop         = out_ready_i & ~empty;
    assign push        = in_valid_i & in_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (AddrW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (AddrW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/spi_rx_deserializer.sv
// SPI slave receive path: synchronizes the SPI pins into clk, assembles
// WORD_W-bit words MSB first (1 or 4 bits per SCLK rising edge) and buffers
// them in a small FIFO.
//   clk, rst            : system clock, synchronous active-high reset
//   spi_sclk_i          : SPI clock pad (asynchronous)
//   spi_csn_i           : SPI chip select pad, active low (asynchronous)
//   spi_sdi_i[3:0]      : SPI data pads; only bit 0 used in standard mode
//   quad_en_i           : mode select, latched at frame start
//   word_if (master)    : word_data_o / word_valid_o / word_ready_i stream
//   frame_start_o       : one-cycle pulse on csn falling edge
//   frame_end_o         : one-cycle pulse on csn rising edge
//   frag_o              : pulses with frame_end_o if the frame ended mid-word
//   overflow_o          : sticky, a word was dropped on a full buffer
//   clr_overflow_i      : clears overflow_o (a coincident new drop wins)
module spi_rx_deserializer
    import spi_rx_pkg::*;
#(
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_sclk_i,
    input  logic                   spi_csn_i,
    input  logic [3:0]             spi_sdi_i,
    input  logic                   quad_en_i,
    spi_rx_deserializer_if.master  word_if,
    output logic                   frame_start_o,
    output logic                   frame_end_o,
    output logic                   frag_o,
    output logic                   overflow_o,
    input  logic                   clr_overflow_i
);

    localparam int unsigned CntW  = $clog2(WORD_W + 1);
    localparam int unsigned FillW = $clog2(SYNC_STAGES + 2);
    localparam logic [FillW-1:0] FillDone = FillW'(SYNC_STAGES + 1);

    // Synchronizers and edge-detect history.
    logic [SYNC_STAGES-1:0]      sclk_sync_q;
    logic [SYNC_STAGES-1:0]      csn_sync_q;
    logic [SYNC_STAGES-1:0][3:0] sdi_sync_q;
    logic                        sclk_hist_q;
    logic                        csn_hist_q;
    logic [FillW-1:0]            fill_q;
    logic                        sclk_s;
    logic                        csn_s;
    logic [3:0]                  sdi_s;
    logic                        sync_ok;
    logic                        sclk_rise;
    logic                        csn_fall;
    logic                        csn_rise;

    // Frame FSM and datapath.
    rx_state_e         state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [WORD_W-1:0] shreg_q, shreg_d, shifted;
    logic              push;
    logic              start_d, end_d, frag_d;
    logic              start_q, end_q, frag_q;
    logic              overflow_q, overflow_d;

    // Buffer side.
    logic [WORD_W-1:0] fifo_data;
    logic              fifo_valid;
    logic              fifo_in_ready;
    logic              fifo_full;
    logic              pop;
    logic              drop;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            sdi_sync_q  <= '0;
            sclk_hist_q <= 1'b0;
            csn_hist_q  <= 1'b1;
            fill_q      <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn_i};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i};
            sclk_hist_q <= sclk_s;
            csn_hist_q  <= csn_s;
            if (fill_q != FillDone) begin
                fill_q <= fill_q + FillW'(1);
            end
        end
    end

    // The csn chain is preset high; if the pad is already low when reset
    // releases, the chain refilling would look like a falling edge. Edges are
    // ignored until the chain and history hold real pad values, so a frame
    // cut by reset needs a fresh falling edge.
    assign sync_ok   = (fill_q == FillDone);
    assign sclk_rise = sync_ok & sclk_s & ~sclk_hist_q;
    assign csn_fall  = sync_ok & ~csn_s & csn_hist_q;
    assign csn_rise  = sync_ok & csn_s & ~csn_hist_q;

    assign shifted = (mode_q == SPI_QUAD_RX) ? ((shreg_q << 4) | WORD_W'(sdi_s))
                                             : ((shreg_q << 1) | WORD_W'(sdi_s[0]));
    assign cnt_inc = cnt_q + CntW'(bits_per_edge(mode_q));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        start_d = 1'b0;
        end_d   = 1'b0;
        frag_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (csn_fall) begin
                    state_d = StShift;
                    mode_d  = quad_en_i ? SPI_QUAD_RX : SPI_STD;
                    cnt_d   = '0;
                    shreg_d = '0;
                    start_d = 1'b1;
                end
            end
            StShift: begin
                // csn rising takes priority: a coincident sclk edge is not sampled.
                if (csn_rise) begin
                    state_d = StIdle;
                    end_d   = 1'b1;
                    frag_d  = (cnt_q != '0);
                    cnt_d   = '0;
                end else if (sclk_rise) begin
                    shreg_d = shifted;
                    if (cnt_inc == CntW'(WORD_W)) begin
                        push  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign pop        = fifo_valid & word_if.word_ready_i;
    assign drop       = push & fifo_full & ~pop;
    assign overflow_d = (overflow_q & ~clr_overflow_i) | drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mode_q     <= SPI_STD;
            cnt_q      <= '0;
            shreg_q    <= '0;
            start_q    <= 1'b0;
            end_q      <= 1'b0;
            frag_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            start_q    <= start_d;
            end_q      <= end_d;
            frag_q     <= frag_d;
            overflow_q <= overflow_d;
        end
    end

    spi_rx_fifo #(
        .Width (WORD_W),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (shifted),
        .in_valid_i  (push),
        .in_ready_o  (fifo_in_ready),
        .out_data_o  (fifo_data),
        .out_valid_o (fifo_valid),
        .out_ready_i (word_if.word_ready_i),
        .full_o      (fifo_full)
    );

    assign word_if.word_data_o  = fifo_data;
    assign word_if.word_valid_o = fifo_valid;
    assign frame_start_o        = start_q;
    assign frame_end_o          = end_q;
    assign frag_o               = frag_q;
    assign overflow_o           = overflow_q;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// Directed + randomized bench for spi_rx_deserializer: drives SPI frames on
// the pads (SCLK half period = 5 clk cycles) and checks received words,
// frame pulses and overflow behaviour against a word-level model.
module tb_spi_rx_deserializer;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       csn = 1'b1;
    logic [3:0] sdi = 4'h0;
    logic       quad = 1'b0;
    logic       clr = 1'b0;
    logic       ready = 1'b0;
    logic       frame_start, frame_end, frag, overflow;

    int unsigned compared = 0;
    int unsigned mismatched = 0;
    int start_cnt = 0, end_cnt = 0, frag_cnt = 0, frag_with_end = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [3:0]  sym_q[$];

    spi_rx_deserializer_if #(.WORD_W(WORD_W)) word_if ();
    assign word_if.word_ready_i = ready;

    spi_rx_deserializer #(
        .WORD_W      (WORD_W),
        .SYNC_STAGES (2),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .spi_sclk_i     (sclk),
        .spi_csn_i      (csn),
        .spi_sdi_i      (sdi),
        .quad_en_i      (quad),
        .word_if        (word_if),
        .frame_start_o  (frame_start),
        .frame_end_o    (frame_end),
        .frag_o         (frag),
        .overflow_o     (overflow),
        .clr_overflow_i (clr)
    );

    always #5 clk = ~clk;

    // Outputs are stable between edges; the handshake seen here is the one
    // completing at the next rising edge.
    always @(negedge clk) begin
        if (frame_start) start_cnt++;
        if (frame_end) end_cnt++;
        if (frag) begin
            frag_cnt++;
            if (frame_end) frag_with_end++;
        end
        if (word_if.word_valid_o && word_if.word_ready_i) got_q.push_back(word_if.word_data_o);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Symbols of a full word, MSB first.
    task automatic load_word(input logic [31:0] w, input bit q);
        sym_q.delete();
        if (q) for (int i = 7; i >= 0; i--) sym_q.push_back(w[4*i +: 4]);
        else   for (int i = 31; i >= 0; i--) sym_q.push_back({3'b000, w[i]});
    endtask

    task automatic load_random(input bit q, input int n);
        sym_q.delete();
        for (int i = 0; i < n; i++) sym_q.push_back(q ? 4'($urandom_range(15, 0)) : 4'($urandom_range(1, 0)));
    endtask

    // Reference: the word is the symbol stream read as a base-2 / base-16 number.
    function automatic logic [31:0] model_assemble(input bit q);
        logic [63:0] acc = 0;
        foreach (sym_q[i]) acc = acc * (q ? 16 : 2) + 64'(sym_q[i]);
        return acc[31:0];
    endfunction

    // hook 1: pulse ready, hook 2: pulse clr, exactly at the clk edge where the
    // last symbol's SCLK rise is acted on (pad + 2 sync stages -> 3rd edge).
    task automatic send_syms(input bit q, input int hook);
        for (int i = 0; i < sym_q.size(); i++) begin
            sdi = q ? sym_q[i] : {3'b000, sym_q[i][0]};
            tick(5);
            sclk = 1'b1;
            if (i == sym_q.size() - 1 && hook != 0) begin
                tick(2);
                if (hook == 1) ready = 1'b1; else clr = 1'b1;
                tick(1);
                ready = 1'b0;
                clr = 1'b0;
                tick(2);
            end else begin
                tick(5);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic csn_low(input bit q);
        quad = q;
        tick(1);
        csn = 1'b0;
        tick(6);
    endtask

    task automatic csn_high();
        tick(5);
        csn = 1'b1;
        tick(12);
    endtask

    task automatic run_frame(input bit q, input int hook);
        csn_low(q);
        send_syms(q, hook);
        csn_high();
    endtask

    initial begin
        int s_start, s_end, s_frag, s_fwe;
        bit q;
        int unsigned mcnt;
        bit movf;

        // Reset state
        tick(4);
        check("rst_valid", 64'(word_if.word_valid_o), 0);
        check("rst_overflow", 64'(overflow), 0);
        check("rst_pulses", 64'(start_cnt + end_cnt + frag_cnt), 0);
        rst = 1'b0;
        tick(5);
        ready = 1'b1;

        // Standard mode 0xDEADBEEF
        s_start = start_cnt; s_end = end_cnt; s_frag = frag_cnt;
        load_word(32'hDEADBEEF, 0);
        run_frame(0, 0);
        check("std_count", 64'(got_q.size()), 1);
        if (got_q.size() > 0) check("std_word", 64'(got_q[0]), 64'h DEADBEEF);
        check("std_start", 64'(start_cnt - s_start), 1);
        check("std_end", 64'(end_cnt - s_end), 1);
        check("std_nofrag", 64'(frag_cnt - s_frag), 0);
        got_q.delete();

        // Quad mode nibbles 1..8
        sym_q.delete();
        for (int i = 1; i <= 8; i++) sym_q.push_back(4'(i));
        run_frame(1, 0);
        check("quad_count", 64'(got_q.size()), 1);
        if (got_q.size() > 0) check("quad_word", 64'(got_q[0]), 64'h12345678);
        got_q.delete();

        // Random frames, random mode
        exp_q.delete();
        s_frag = frag_cnt;
        for (int f = 0; f < 6; f++) begin
            q = 1'($urandom_range(1, 0));
            load_random(q, q ? 8 : 32);
            exp_q.push_back(model_assemble(q));
            run_frame(q, 0);
        end
        check("rand_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        check("rand_nofrag", 64'(frag_cnt - s_frag), 0);
        got_q.delete();

        // Frame cut after 12 bits
        s_end = end_cnt; s_frag = frag_cnt; s_fwe = frag_with_end;
        load_random(0, 12);
        run_frame(0, 0);
        check("frag_noword", 64'(got_q.size()), 0);
        check("frag_pulse", 64'(frag_cnt - s_frag), 1);
        check("frag_with_end", 64'(frag_with_end - s_fwe), 1);
        check("frag_end", 64'(end_cnt - s_end), 1);

        // Overflow: consumer stalled, 5 words into a 4-deep buffer
        ready = 1'b0;
        exp_q.delete(); mcnt = 0; movf = 0;
        for (int f = 0; f < 5; f++) begin
            load_random(0, 32);
            if (mcnt < DEPTH) begin exp_q.push_back(model_assemble(0)); mcnt++; end
            else movf = 1;
            run_frame(0, 0);
        end
        check("ovf_set", 64'(overflow), 64'(movf));
        tick(20);
        check("ovf_sticky", 64'(overflow), 64'(movf));
        ready = 1'b1;
        tick(10);
        check("ovf_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("ovf_word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        check("ovf_held_until_clr", 64'(overflow), 1);
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
        check("ovf_cleared", 64'(overflow), 0);
        got_q.delete();

        // Clear coinciding with a new drop: drop wins
        ready = 1'b0;
        for (int f = 0; f < 4; f++) begin load_random(0, 32); run_frame(0, 0); end
        load_random(0, 32);
        run_frame(0, 2);
        check("clr_vs_drop", 64'(overflow), 1);
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
        check("clr_after", 64'(overflow), 0);
        ready = 1'b1;
        tick(10);
        check("clr_drain", 64'(got_q.size()), 4);
        got_q.delete();

        // Full buffer with pop and push on the same edge
        ready = 1'b0;
        exp_q.delete();
        for (int f = 0; f < 5; f++) begin
            load_random(1, 8);
            exp_q.push_back(model_assemble(1));
            run_frame(1, (f == 4) ? 1 : 0);
        end
        check("pp_noovf", 64'(overflow), 0);
        ready = 1'b1;
        tick(10);
        check("pp_count", 64'(got_q.size()), 5);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("pp_word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();

        // Reset mid-frame, then a fresh frame
        csn_low(0);
        load_random(0, 20);
        send_syms(0, 0);
        rst = 1'b1; tick(3); rst = 1'b0;
        check("mid_rst_valid", 64'(word_if.word_valid_o), 0);
        s_start = start_cnt; s_end = end_cnt;
        tick(3);
        load_random(0, 12);
        send_syms(0, 0);
        csn_high();
        check("mid_rst_idle_start", 64'(start_cnt - s_start), 0);
        check("mid_rst_idle_end", 64'(end_cnt - s_end), 0);
        check("mid_rst_noword", 64'(got_q.size()), 0);
        load_word(32'h00000001, 0);
        run_frame(0, 0);
        check("mid_rst_count", 64'(got_q.size()), 1);
        if (got_q.size() > 0) check("mid_rst_word", 64'(got_q[0]), 64'h1);
        check("mid_rst_start", 64'(start_cnt - s_start), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
